// File: rtl/router_pkg.sv
// Shared constants and the stored FIFO word layout for the router output buffers.
// Header byte layout: [HDR_ADDR_MSB:HDR_ADDR_LSB] destination, [HDR_LEN_MSB:HDR_LEN_LSB] payload length.
// No ports; imported by router_fifo and router_fifo_mem users.
package router_pkg;

  localparam int DATA_W       = 8;
  localparam int FIFO_DEPTH   = 16;

  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;

  // Holds payload length + 1 (parity byte): up to 64, so one bit wider than the length field.
  localparam int PKT_CNT_W    = HDR_LEN_MSB - HDR_LEN_LSB + 2;

  // tag = 1 marks the header byte of a packet.
  typedef struct packed {
    logic              tag;
    logic [DATA_W-1:0] data;
  } fifo_word_t;

endpackage

// File: rtl/router_fifo_mem.sv
// Storage array for router_fifo: DEPTH x WIDTH, one write port, one synchronous read port.
// Latency: read word appears on rd_word one edge after rd_en; rd_word holds when rd_en is low.
// Ports: clock, reset (async, clears rd_word only), clear (sync rd_word clear), wr_en/wr_addr/wr_word,
//        rd_en/rd_addr/rd_word. The array itself is never reset.
module router_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_word,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_word
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
  end

  // Read register doubles as the FIFO's data_out register, so it is resettable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_word <= '0;
    end else if (clear) begin
      rd_word <= '0;
    end else if (rd_en) begin
      rd_word <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/router_fifo.sv
// Per-destination packet buffer: stores bytes from router_reg with a header tag, drains to the client.
// Latency: data_out/data_out_vld one edge after an accepted read; pkt_active reflects that byte one edge later.
// Backpressure: full blocks writes (byte dropped, router_reg holds it); empty ignores reads.
// Ports: clock, reset (async high), soft_reset (sync flush), write_enb, lfd_state, data_in,
//        read_enb, data_out, data_out_vld, full, empty, pkt_active.
// Build option ROUTER_FIFO_OVF_EN adds a sticky 'overflow' output (write attempted while full).
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enb,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_vld,
  output logic              full,
  output logic              empty,
  output logic              pkt_active
`ifdef ROUTER_FIFO_OVF_EN
  ,
  output logic              overflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        occ;
  logic                 lfd_q;
  logic [PKT_CNT_W-1:0] pkt_cnt;
  logic                 wr_ok;
  logic                 rd_ok;
  fifo_word_t           wr_word;
  fifo_word_t           rd_word;

  assign full  = (occ == CW'(DEPTH));
  assign empty = (occ == '0);

  // A flush cycle swallows any concurrent read or write.
  assign wr_ok = write_enb && !full  && !soft_reset;
  assign rd_ok = read_enb  && !empty && !soft_reset;

  // Header tag comes from lfd_state one cycle earlier, matching router_reg's dout delay.
  assign wr_word = '{tag: lfd_q, data: data_in};

  router_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fifo_word_t))
  ) u_mem (
    .clock   (clock),
    .reset   (reset),
    .clear   (soft_reset),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_word (wr_word),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr),
    .rd_word (rd_word)
  );

  assign data_out   = rd_word.data;
  assign pkt_active = (pkt_cnt != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      lfd_q        <= 1'b0;
      data_out_vld <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      lfd_q        <= 1'b0;
      data_out_vld <= 1'b0;
    end else begin
      lfd_q        <= lfd_state;
      data_out_vld <= rd_ok;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Packet tracking works off the registered read word, so it acts on the
  // cycle where data_out_vld marks a fresh byte. A header always reloads,
  // which also covers a truncated previous packet.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pkt_cnt <= '0;
    end else if (soft_reset) begin
      pkt_cnt <= '0;
    end else if (data_out_vld) begin
      if (rd_word.tag) begin
        pkt_cnt <= PKT_CNT_W'(rd_word.data[HDR_LEN_MSB:HDR_LEN_LSB]) + PKT_CNT_W'(1);
      end else if (pkt_cnt != '0) begin
        pkt_cnt <= pkt_cnt - PKT_CNT_W'(1);
      end
    end
  end

`ifdef ROUTER_FIFO_OVF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (soft_reset) begin
      overflow <= 1'b0;
    end else if (write_enb && full) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed scenarios followed by random traffic,
// all compared against a queue-based reference model after every clock edge.
module tb_router_fifo;

  localparam int DEPTH = 16;

  logic       clock;
  logic       reset;
  logic       soft_reset;
  logic       write_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic       read_enb;
  logic [7:0] data_out;
  logic       data_out_vld;
  logic       full;
  logic       empty;
  logic       pkt_active;
`ifdef ROUTER_FIFO_OVF_EN
  logic       overflow;
`endif

  router_fifo #(.DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .soft_reset   (soft_reset),
    .write_enb    (write_enb),
    .lfd_state    (lfd_state),
    .data_in      (data_in),
    .read_enb     (read_enb),
    .data_out     (data_out),
    .data_out_vld (data_out_vld),
    .full         (full),
    .empty        (empty),
    .pkt_active   (pkt_active)
`ifdef ROUTER_FIFO_OVF_EN
    ,
    .overflow     (overflow)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as a queue of {tag, byte}.
  logic [8:0] q[$];
  logic       m_lfd_q;
  logic [7:0] m_dout;
  logic       m_vld;
  logic [8:0] m_last;
  int         m_pkt;
  logic       m_ovf;

  task automatic model_clear();
    q.delete();
    m_lfd_q = 1'b0;
    m_dout  = 8'h00;
    m_vld   = 1'b0;
    m_last  = 9'h000;
    m_pkt   = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", name, obs, exp, $time);
      $error("check %s failed", name);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".data_out"},     32'(data_out),     32'(m_dout));
    chk({tag, ".data_out_vld"}, 32'(data_out_vld), 32'(m_vld));
    chk({tag, ".full"},         32'(full),         32'(q.size() == DEPTH));
    chk({tag, ".empty"},        32'(empty),        32'(q.size() == 0));
    chk({tag, ".pkt_active"},   32'(pkt_active),   32'(m_pkt != 0));
`ifdef ROUTER_FIFO_OVF_EN
    chk({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
`endif
  endtask

  // One clock cycle: drive inputs, take the edge, advance the model, check.
  task automatic step(input logic we, input logic lfd, input logic [7:0] din,
                      input logic re, input logic sr, input string tag);
    logic do_rd;
    logic do_wr;
    write_enb  = we;
    lfd_state  = lfd;
    data_in    = din;
    read_enb   = re;
    soft_reset = sr;
    @(posedge clock);
    // A byte delivered last cycle updates the packet count at this edge.
    if (m_vld) begin
      if (m_last[8]) m_pkt = int'(m_last[7:2]) + 1;
      else if (m_pkt != 0) m_pkt = m_pkt - 1;
    end
    if (sr) begin
      model_clear();
    end else begin
      do_rd = re && (q.size() != 0);
      do_wr = we && (q.size() < DEPTH);
      if (we && q.size() == DEPTH) m_ovf = 1'b1;
      if (do_rd) begin
        m_last = q.pop_front();
        m_dout = m_last[7:0];
        m_vld  = 1'b1;
      end else begin
        m_vld = 1'b0;
      end
      if (do_wr) q.push_back({m_lfd_q, din});
      m_lfd_q = lfd;
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    reset      = 1'b1;
    soft_reset = 1'b0;
    write_enb  = 1'b0;
    lfd_state  = 1'b0;
    data_in    = 8'h00;
    read_enb   = 1'b0;
    model_clear();
    #3;
    check_outputs("reset");
    @(negedge clock);
    reset = 1'b0;

    // Fill with one packet: header 0x0D (length 3) plus filler bytes.
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, "pre_hdr");
    step(1'b1, 1'b0, 8'h0D, 1'b0, 1'b0, "wr_hdr");
    for (int i = 1; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0, 1'b0, "wr_fill");
    step(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, "wr_drop");
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "full_idle");

    // Header then four more bytes: count goes 4,3,2,1,0.
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "rd_hdr");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "rd_pay");
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "pkt_done");

    // Drain to 8, then 20 cycles of simultaneous read+write across the wrap.
    while (q.size() > 8) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "drain8");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b1, 1'b0, "rw_steady");

    // Drain completely, then read empty and write+read on empty.
    while (q.size() > 0) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "drain0");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "rd_empty");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "rd_empty2");
    step(1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, "wr_rd_empty");

    // Occupancy 5 mid-packet, then soft_reset with concurrent read/write.
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, "pre_hdr2");
    step(1'b1, 1'b0, 8'h21, 1'b0, 1'b0, "wr_hdr2");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b0, "wr_pay2");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "rd_old");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "rd_hdr2");
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "pkt_on2");
    chk("occ_before_soft", 32'(q.size()), 32'd5);
    step(1'b1, 1'b0, 8'h77, 1'b1, 1'b1, "soft_reset");
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "after_soft");

    // Async reset mid-write, without any clock edge.
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, "pre_hdr3");
    step(1'b1, 1'b0, 8'h09, 1'b0, 1'b0, "wr_hdr3");
    step(1'b1, 1'b0, 8'h33, 1'b1, 1'b0, "wr_rd3");
    write_enb = 1'b1;
    data_in   = 8'h34;
    read_enb  = 1'b1;
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check_outputs("async_reset");
    @(negedge clock);
    reset = 1'b0;

    // Fill, attempt writes at full, hold, then flush.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h80 + i), 1'b0, 1'b0, "ovf_fill");
    step(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, "ovf_write");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "ovf_hold1");
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "ovf_hold2");
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "ovf_soft");

    // Random traffic with occasional headers and flushes.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 9) < 6), ($urandom_range(0, 4) == 0), 8'($urandom),
           ($urandom_range(0, 9) < 5), ($urandom_range(0, 59) == 0), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
